// File: rtl/axi_mem_slave.sv
// AXI responder data RAM: DEPTH words of DATA_W bits, independent write (AW/W/B) and read (AR/R) FSMs.
// Optional macro AXI_MEM_WAIT_EN adds WAIT_CYC-cycle wait states ahead of the B and R responses.
module axi_mem_slave #(
    parameter int unsigned       ADDR_W    = 64,
    parameter int unsigned       DATA_W    = 64,
    parameter int unsigned       STRB_W    = 8,
    parameter int unsigned       DEPTH     = 4096,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(64'h8000_0000),
    parameter int unsigned       WAIT_CYC  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              awvalid,
    output logic              awready,
    input  logic              awid,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              wvalid,
    output logic              wready,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    output logic              bvalid,
    input  logic              bready,
    output logic              bresp,
    input  logic              arvalid,
    output logic              arready,
    input  logic [ADDR_W-1:0] araddr,
    output logic              rvalid,
    input  logic              rready,
    output logic [DATA_W-1:0] rdata,
    output logic              rresp
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned SH    = $clog2(STRB_W);

`ifdef AXI_MEM_WAIT_EN
    localparam logic              WAIT_ON  = (WAIT_CYC != 0);
    localparam int unsigned       CNT_W    = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(WAIT_CYC - 1);

    typedef enum logic [2:0] {W_IDLE, W_DATA, W_ADDR, W_RESP, W_WAIT} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_DATA, R_WAIT} r_state_t;
`else
    typedef enum logic [2:0] {W_IDLE, W_DATA, W_ADDR, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_DATA} r_state_t;
`endif

    // awid carries no meaning for a single in-order responder
    logic unused_c;
    assign unused_c = ^{awid, WAIT_CYC[0]};

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (a >= BASE_ADDR) && (((a - BASE_ADDR) >> SH) < ADDR_W'(DEPTH));
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
        return IDX_W'((a - BASE_ADDR) >> SH);
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    // ---------------- write channel ----------------
    w_state_t          w_state, w_next;
    logic [ADDR_W-1:0] aw_addr_q;
    logic [DATA_W-1:0] w_data_q;
    logic [STRB_W-1:0] w_strb_q;
    logic              commit_c, aw_lat_c, w_lat_c;
    logic [ADDR_W-1:0] cm_addr_c;
    logic [DATA_W-1:0] cm_data_c;
    logic [STRB_W-1:0] cm_strb_c;
`ifdef AXI_MEM_WAIT_EN
    logic [CNT_W-1:0]  wcnt;
`endif

    always_comb begin
        w_next    = w_state;
        commit_c  = 1'b0;
        aw_lat_c  = 1'b0;
        w_lat_c   = 1'b0;
        cm_addr_c = aw_addr_q;
        cm_data_c = w_data_q;
        cm_strb_c = w_strb_q;
        case (w_state)
            W_IDLE: begin
                if (awvalid && wvalid) begin
                    commit_c  = 1'b1;
                    cm_addr_c = awaddr;
                    cm_data_c = wdata;
                    cm_strb_c = wstrb;
                end else if (awvalid) begin
                    aw_lat_c = 1'b1;
                    w_next   = W_DATA;
                end else if (wvalid) begin
                    w_lat_c = 1'b1;
                    w_next  = W_ADDR;
                end
            end
            W_DATA: begin
                if (wvalid) begin
                    commit_c  = 1'b1;
                    cm_data_c = wdata;
                    cm_strb_c = wstrb;
                end
            end
            W_ADDR: begin
                if (awvalid) begin
                    commit_c  = 1'b1;
                    cm_addr_c = awaddr;
                end
            end
            W_RESP: begin
                if (bready) w_next = W_IDLE;
            end
`ifdef AXI_MEM_WAIT_EN
            W_WAIT: begin
                if (wcnt == '0) w_next = W_RESP;
            end
`endif
            default: w_next = W_IDLE;
        endcase
        // every completed AW/W pair lands here, whichever handshake came last
        if (commit_c) begin
            w_next = W_RESP;
`ifdef AXI_MEM_WAIT_EN
            if (WAIT_ON) w_next = W_WAIT;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state   <= W_IDLE;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bresp     <= 1'b0;
            awready   <= 1'b1;
            wready    <= 1'b1;
            bvalid    <= 1'b0;
        end else begin
            w_state <= w_next;
            if (aw_lat_c) aw_addr_q <= awaddr;
            if (w_lat_c) begin
                w_data_q <= wdata;
                w_strb_q <= wstrb;
            end
            if (commit_c) bresp <= !addr_ok(cm_addr_c);
            else if (w_state == W_RESP && bready) bresp <= 1'b0;
            awready <= (w_next == W_IDLE) || (w_next == W_ADDR);
            wready  <= (w_next == W_IDLE) || (w_next == W_DATA);
            bvalid  <= (w_next == W_RESP);
        end
    end

`ifdef AXI_MEM_WAIT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 wcnt <= '0;
        else if (commit_c)          wcnt <= CNT_LOAD;
        else if (w_state == W_WAIT) wcnt <= wcnt - CNT_W'(1);
    end
`endif

    // byte-lane merge; out-of-range commits leave the array untouched
    always_ff @(posedge clk) begin
        if (commit_c && rst_n && addr_ok(cm_addr_c)) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (cm_strb_c[i]) mem[addr_idx(cm_addr_c)][8*i +: 8] <= cm_data_c[8*i +: 8];
            end
        end
    end

    // ---------------- read channel ----------------
    r_state_t          r_state, r_next;
    logic              rd_load_c;
    logic [ADDR_W-1:0] rd_addr_c;
`ifdef AXI_MEM_WAIT_EN
    logic              ar_lat_c;
    logic [ADDR_W-1:0] ar_addr_q;
    logic [CNT_W-1:0]  rcnt;
`endif

    always_comb begin
        r_next    = r_state;
        rd_load_c = 1'b0;
        rd_addr_c = araddr;
`ifdef AXI_MEM_WAIT_EN
        ar_lat_c  = 1'b0;
`endif
        case (r_state)
            R_IDLE: begin
                if (arvalid) begin
`ifdef AXI_MEM_WAIT_EN
                    ar_lat_c = 1'b1;
                    if (WAIT_ON) begin
                        r_next = R_WAIT;
                    end else begin
                        r_next    = R_DATA;
                        rd_load_c = 1'b1;
                    end
`else
                    r_next    = R_DATA;
                    rd_load_c = 1'b1;
`endif
                end
            end
            R_DATA: begin
                if (rready) r_next = R_IDLE;
            end
`ifdef AXI_MEM_WAIT_EN
            R_WAIT: begin
                if (rcnt == '0) begin
                    r_next    = R_DATA;
                    rd_load_c = 1'b1;
                    rd_addr_c = ar_addr_q;
                end
            end
`endif
            default: r_next = R_IDLE;
        endcase
    end

    // array sampled at the capture edge, so a same-edge write is not yet visible
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= R_IDLE;
            arready <= 1'b1;
            rvalid  <= 1'b0;
            rdata   <= '0;
            rresp   <= 1'b0;
        end else begin
            r_state <= r_next;
            arready <= (r_next == R_IDLE);
            rvalid  <= (r_next == R_DATA);
            if (rd_load_c) begin
                rdata <= addr_ok(rd_addr_c) ? mem[addr_idx(rd_addr_c)] : '0;
                rresp <= !addr_ok(rd_addr_c);
            end else if (r_state == R_DATA && rready) begin
                rdata <= '0;
                rresp <= 1'b0;
            end
        end
    end

`ifdef AXI_MEM_WAIT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ar_addr_q <= '0;
            rcnt      <= '0;
        end else begin
            if (ar_lat_c) ar_addr_q <= araddr;
            if (ar_lat_c)               rcnt <= CNT_LOAD;
            else if (r_state == R_WAIT) rcnt <= rcnt - CNT_W'(1);
        end
    end
`endif

endmodule
